uart_cmd_wrapper: RTL and testbench

//  Device-side end of the remote command link. Receives a 16-bit command as two

---
 rtl/remote_comm_pkg.sv | 8 +
 rtl/uart_cmd_wrapper_if.sv | 27 ++
 rtl/uart_cmd_wrapper_uart.sv | 104 ++++++++++
 rtl/uart_cmd_wrapper.sv | 119 +++++++++++
 tb/tb_uart_cmd_wrapper.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types and widths for the remote command link.
package remote_comm_pkg;
  localparam int CMD_W      = 16;
  localparam int BYTE_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [0:0] {HIGH, LOW} cmd_rx_state_t;
endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Command/response bus between the link wrapper and the command-processing logic.
interface uart_cmd_wrapper_if;
  import remote_comm_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic [BYTE_W-1:0] resp;
  logic              trmt;
  logic              tx_busy;
  logic              resp_sent;
  logic              frame_err;
  cmd_rx_state_t     rx_state;

  // Handshake: cmd is valid while cmd_rdy=1 and holds until the next full command;
  // clr_cmd_rdy is the consumer's ready/ack. trmt is a 1-cycle request, accepted
  // only while tx_busy=0; resp_sent pulses once when the byte is fully shifted out.
  modport slave (
    output cmd, cmd_rdy, tx_busy, resp_sent, frame_err, rx_state,
    input  clr_cmd_rdy, resp, trmt
  );

  modport master (
    input  cmd, cmd_rdy, tx_busy, resp_sent, frame_err, rx_state,
    output clr_cmd_rdy, resp, trmt
  );
endinterface

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART transceiver; BAUD_DIV clocks per bit, RX sampled mid-bit after a 2-flop sync.
module uart_cmd_wrapper_uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_rdy,
  input  logic              clr_rx_rdy,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              trmt,
  output logic              tx_done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic              rx_meta, rx_s;
  logic              rx_busy;
  logic [BW-1:0]     rx_baud;
  logic [3:0]        rx_bits;
  logic [BYTE_W-1:0] rx_shift;

  logic                  tx_busy;
  logic [BW-1:0]         tx_baud;
  logic [3:0]            tx_bits;
  logic [FRAME_BITS-1:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_s, rx_meta} <= 2'b11;
    else        {rx_s, rx_meta} <= {rx_meta, RX};
  end

  // Sample points: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_baud <= HALF;
          rx_bits <= '0;
        end
      end else if (rx_baud == '0) begin
        rx_baud <= FULL;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == LAST_BIT) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
          rx_data <= rx_shift;
        end else if (rx_bits != 4'd0) begin
          rx_shift <= {rx_s, rx_shift[BYTE_W-1:1]};
        end
      end else begin
        rx_baud <= rx_baud - 1'b1;
      end
    end
  end

  // Idle shifter is all ones, so the line rests high between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_shift <= {1'b1, tx_data, 1'b0};
          tx_busy  <= 1'b1;
          tx_baud  <= FULL;
          tx_bits  <= '0;
        end
      end else if (tx_baud == '0) begin
        tx_baud  <= FULL;
        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
        tx_bits  <= tx_bits + 4'd1;
        if (tx_bits == LAST_BIT) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        tx_baud <= tx_baud - 1'b1;
      end
    end
  end

  assign TX = tx_shift[0];
endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command and sends 1-byte responses.
module uart_cmd_wrapper
  import remote_comm_pkg::*;
#(
  parameter int TO_CYCLES = 1_000_000,
  parameter int BAUD_DIV  = 2604
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RX,
  output logic                TX,
  uart_cmd_wrapper_if.slave   bus
);
  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_rdy;
  logic              clr_rx_rdy;
  logic              tx_done;
  logic              uart_trmt;

  cmd_rx_state_t     state, state_nxt;
  logic [BYTE_W-1:0] hi_byte, hi_byte_nxt;
  logic [CMD_W-1:0]  cmd_q, cmd_nxt;
  logic              cmd_rdy_q, cmd_rdy_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              frame_err_q, frame_err_nxt;
  logic              tx_busy_q, resp_sent_q;

  uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) iUART (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .tx_data    (bus.resp),
    .trmt       (uart_trmt),
    .tx_done    (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HIGH;
      hi_byte     <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      to_cnt      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      hi_byte     <= hi_byte_nxt;
      cmd_q       <= cmd_nxt;
      cmd_rdy_q   <= cmd_rdy_nxt;
      to_cnt      <= to_cnt_nxt;
      frame_err_q <= frame_err_nxt;
    end
  end

  // A completing low byte sets cmd_rdy even when clr_cmd_rdy is asserted that cycle.
  always_comb begin
    state_nxt     = state;
    hi_byte_nxt   = hi_byte;
    cmd_nxt       = cmd_q;
    cmd_rdy_nxt   = cmd_rdy_q & ~bus.clr_cmd_rdy;
    to_cnt_nxt    = to_cnt;
    frame_err_nxt = 1'b0;
    clr_rx_rdy    = 1'b0;
    case (state)
      HIGH: begin
        if (rx_rdy) begin
          clr_rx_rdy  = 1'b1;
          hi_byte_nxt = rx_data;
          cmd_rdy_nxt = 1'b0;
          to_cnt_nxt  = '0;
          state_nxt   = LOW;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          clr_rx_rdy  = 1'b1;
          cmd_nxt     = {hi_byte, rx_data};
          cmd_rdy_nxt = 1'b1;
          state_nxt   = HIGH;
        end else if (to_cnt == TO_LAST) begin
          frame_err_nxt = 1'b1;
          hi_byte_nxt   = '0;
          state_nxt     = HIGH;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = HIGH;
    endcase
  end

  // Requests arriving while a byte is in flight are dropped, not queued.
  assign uart_trmt = bus.trmt & ~tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= tx_done;
      if (tx_done)        tx_busy_q <= 1'b0;
      else if (uart_trmt) tx_busy_q <= 1'b1;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.resp_sent = resp_sent_q;
  assign bus.rx_state  = state;
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: serial host model, command and response scoreboards.
module tb_uart_cmd_wrapper;
  import remote_comm_pkg::*;

  localparam int BAUD = 16;
  localparam int TO   = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;

  uart_cmd_wrapper_if bus();

  uart_cmd_wrapper #(.TO_CYCLES(TO), .BAUD_DIV(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CMD_W-1:0]  exp_q[$];
  logic [BYTE_W-1:0] exp_tx_q[$];
  int fe_cnt = 0;
  int rs_cnt = 0;
  logic             prev_rdy = 1'b0;
  logic [CMD_W-1:0] prev_cmd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Command monitor: cmd may only change on a cmd_rdy rising edge, and each rise pops one entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected actual=%h required=none", bus.cmd);
        end else begin
          check("cmd_value", 32'(bus.cmd), 32'(exp_q.pop_front()));
        end
      end else begin
        check("cmd_hold", 32'(bus.cmd), 32'(prev_cmd));
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.resp_sent) rs_cnt++;
    end
    prev_rdy = bus.cmd_rdy;
    prev_cmd = bus.cmd;
  end

  // Host-side receiver on TX.
  initial begin : host_rx
    logic [BYTE_W-1:0] b;
    forever begin
      @(negedge TX);
      repeat (BAUD / 2) @(negedge clk);
      for (int i = 0; i < BYTE_W; i++) begin
        repeat (BAUD) @(negedge clk);
        b[i] = TX;
      end
      repeat (BAUD) @(negedge clk);
      check("tx_stop_bit", 32'(TX), 32'd1);
      if (exp_tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=%h required=none", b);
      end else begin
        check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [BYTE_W-1:0] b);
    logic [FRAME_BITS-1:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      RX = f[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [CMD_W-1:0] c, input int gap);
    exp_q.push_back(c);
    send_byte(c[15:8]);
    repeat (gap) @(posedge clk);
    #1;
    send_byte(c[7:0]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("cmd_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("clr_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
  endtask

  task automatic send_resp(input logic [BYTE_W-1:0] r, input logic expect_accept);
    @(posedge clk); #1;
    bus.resp = r;
    bus.trmt = 1'b1;
    if (expect_accept) exp_tx_q.push_back(r);
    @(posedge clk); #1;
    bus.trmt = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (rs_cnt < target && n < 20 * BAUD) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("resp_sent_wait", 32'(rs_cnt), 32'(target));
    check("tx_busy_after", 32'(bus.tx_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_cmd"}, 32'(bus.cmd), 32'd0);
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'd0);
    check({tag, "_tx"}, 32'(TX), 32'd1);
    check({tag, "_tx_busy"}, 32'(bus.tx_busy), 32'd0);
    check({tag, "_resp_sent"}, 32'(bus.resp_sent), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin : main
    int fe0;
    int rs0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0;
    bus.trmt = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Basic command and hold until acknowledged.
    send_cmd(16'hA55A, 0);
    wait_drain();
    repeat (50) @(negedge clk);
    check("cmd_rdy_hold", 32'(bus.cmd_rdy), 32'd1);
    check("cmd_a55a", 32'(bus.cmd), 32'hA55A);
    pulse_clr();

    // Back-to-back commands without acknowledge.
    send_cmd(16'h1234, 5);
    wait_drain();
    exp_q.push_back(16'hBEEF);
    send_byte(8'hBE);
    @(negedge clk);
    check("drop_on_high", 32'(bus.cmd_rdy), 32'd0);
    send_byte(8'hEF);
    wait_drain();
    check("cmd_beef", 32'(bus.cmd), 32'hBEEF);
    pulse_clr();

    // Completion while clr_cmd_rdy is held: set wins for that cycle.
    bus.clr_cmd_rdy = 1'b1;
    send_cmd(16'hC33C, 2);
    wait_drain();
    check("set_wins_then_clr", 32'(bus.cmd_rdy), 32'd0);
    bus.clr_cmd_rdy = 1'b0;

    // Inter-byte timeout.
    fe0 = fe_cnt;
    send_byte(8'h12);
    repeat (TO + 200) @(posedge clk); #1;
    check("frame_err_once", 32'(fe_cnt), 32'(fe0 + 1));
    check("timeout_no_rdy", 32'(bus.cmd_rdy), 32'd0);
    send_cmd(16'h3456, 0);
    wait_drain();
    check("cmd_3456", 32'(bus.cmd), 32'h3456);
    pulse_clr();
    // Slow but in-time low byte still completes.
    fe0 = fe_cnt;
    send_cmd(16'h9ABC, TO - 400);
    wait_drain();
    check("no_frame_err_in_time", 32'(fe_cnt), 32'(fe0));

    // Response path with an ignored mid-frame request.
    rs0 = rs_cnt;
    send_resp(8'hA5, 1'b1);
    repeat (5 * BAUD) @(posedge clk);
    @(negedge clk);
    check("tx_busy_mid", 32'(bus.tx_busy), 32'd1);
    send_resp(8'hFF, 1'b0);
    wait_resp(rs0 + 1);
    repeat (3 * BAUD) @(posedge clk);
    check("resp_sent_once", 32'(rs_cnt), 32'(rs0 + 1));
    check("tx_drained", 32'(exp_tx_q.size()), 32'd0);

    // Randomized concurrent commands and responses.
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          send_cmd(16'($urandom), $urandom_range(0, 30));
          wait_drain();
          if ($urandom_range(0, 1) == 1) pulse_clr();
          repeat ($urandom_range(0, 20)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(1, 10)) @(posedge clk);
          rs0 = rs_cnt;
          send_resp(8'($urandom), 1'b1);
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 8) * BAUD) @(posedge clk);
            send_resp(8'($urandom), 1'b0);
          end
          wait_resp(rs0 + 1);
        end
      end
    join
    repeat (2 * BAUD) @(posedge clk);
    check("rand_tx_drained", 32'(exp_tx_q.size()), 32'd0);

    // Reset with a partial command pending.
    send_byte(8'h77);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    send_cmd(16'h0102, 3);
    wait_drain();
    check("cmd_0102", 32'(bus.cmd), 32'h0102);

    repeat (10) @(posedge clk);
    check("final_cmd_q", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
